seq_pattern_tx: RTL
===================

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter PAT_W, default 4, pattern width in bits (min 2).
REQ-002 Parameter CNT_W, default 8, repeat-count width.
REQ-003 clk  input  1  clock, all state on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 load_valid  input  1  request to start a transmission.
REQ-006 load_ready  output  1  block can accept a load this cycle.
REQ-007 load_pattern  input  PAT_W  pattern, sent MSB first.
REQ-008 load_repeat  input  CNT_W  frame repetitions; 0 = continuous until abort.
REQ-009 abort  input  1  synchronous cancel of any transmission.
REQ-010 data_out  output  1  serial bit; 0 whenever data_out_valid=0.
REQ-011 data_out_valid  output  1  data_out carries a frame bit.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after last frame of a finite run.

Function
REQ-014 Moore FSM, states IDLE, SHIFT, PARITY (macro only), DONE; all outputs derived from registered state and registers only.
REQ-015 load_ready = (state==IDLE) && !abort; load accepted on an edge where load_valid && load_ready.
REQ-016 Accept: latch pattern into shift register and load_repeat into remaining counter, bit counter = PAT_W-1, go to SHIFT.
REQ-017 First frame bit appears on data_out with data_out_valid=1 in the cycle after acceptance (latency 1).
REQ-018 SHIFT: one bit per cycle MSB first; bit counter decrements; frame = PAT_W bits, back-to-back, no gap cycles.
REQ-019 End of frame (bit counter 0, after PARITY if enabled): repeat=0 -> reload pattern, stay transmitting; remaining>1 -> decrement, reload pattern; remaining==1 -> DONE.
REQ-020 Consecutive frames are contiguous: first bit of frame n+1 in cycle directly after last bit of frame n.
REQ-021 DONE lasts exactly one cycle: done=1, data_out_valid=0, busy=1; then IDLE.
REQ-022 abort has priority over every transition: next edge -> IDLE, no done pulse, data_out_valid=0 from that cycle on.
REQ-023 load_valid outside IDLE is ignored; load_pattern/load_repeat sampled only on acceptance.
REQ-024 Illegal state encodings recover to IDLE on next edge.

Reset
REQ-025 reset_n low: state IDLE, data_out=0, data_out_valid=0, busy=0, done=0, counters and shift register 0; load_ready=1 once reset deasserted.
REQ-026 Reset asserted mid-frame truncates the frame immediately, no done pulse.

Configuration
REQ-027 Macro SEQ_PATTERN_TX_PARITY_EN defined: PARITY state appended after each frame's PAT_W bits, one cycle, data_out = even parity (XOR) of the frame's pattern bits, data_out_valid=1; frame = PAT_W+1 bits.
REQ-028 Macro undefined: no PARITY state, no parity logic; frame = PAT_W bits.

Structure
REQ-029 Package seq_pattern_pkg holds state enum typedef and state encodings shared with the sequence detectors.
REQ-030 One sub-module, seq_shift_reg: PAT_W-bit parallel-load, MSB-out shift register with load/shift enables.

Verification
REQ-031 Pattern 1001, repeat 1: data_out 1,0,0,1 on cycles +1..+4 valid=1; done=1 on +5; load_ready=1 on +6.
REQ-032 Pattern 1001, repeat 3: 12 contiguous valid bits 100110011001, single done pulse; overlapping 1001 detector on the stream fires 3 times.
REQ-033 Pattern 1010, repeat 0: stream continues 40+ cycles; abort on cycle 17 -> valid=0 next cycle, no done, load_ready=1.
REQ-034 Reset asserted on bit 2 of frame: all outputs 0 asynchronously; fresh load afterwards transmits full frame.
REQ-035 load_valid pulsed while busy and together with abort in IDLE: neither accepted, outputs unchanged.
REQ-036 With SEQ_PATTERN_TX_PARITY_EN, repeat 1: pattern 1001 -> 10010, pattern 1011 -> 10111, done on cycle +6.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// seq_pattern_pkg: FSM state encodings shared by the pattern transmitter and the sequence detectors.
package seq_pattern_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;
endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg: parallel-load, MSB-first shift register; load wins over shift.
module seq_shift_reg #(
   parameter int PAT_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             shift,
   input  logic [PAT_W-1:0] din,
   output logic             msb
);
   logic [PAT_W-1:0] q;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) q <= '0;
      else if (load) q <= din;
      else if (shift) q <= {q[PAT_W-2:0], 1'b0};

   assign msb = q[PAT_W-1];
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: repeating serial pattern transmitter with load handshake and abort.
// Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit after every frame.
module seq_pattern_tx
   import seq_pattern_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [PAT_W-1:0] load_pattern,
   input  logic [CNT_W-1:0] load_repeat,
   input  logic             abort,
   output logic             data_out,
   output logic             data_out_valid,
   output logic             busy,
   output logic             done
);
   localparam int BW = $clog2(PAT_W);
   localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);

   state_t state, state_nx;
   logic [PAT_W-1:0] pat;
   logic [CNT_W-1:0] rem;
   logic [BW-1:0] bit_cnt;
   logic accept, reload, sr_shift, frame_end, sr_msb;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      accept = 1'b0;
      sr_shift = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            accept = load_valid;
            state_nx = load_valid ? SHIFT : IDLE;
         end
`ifdef SEQ_PATTERN_TX_PARITY_EN
         SHIFT: begin
            sr_shift = bit_cnt != '0;
            state_nx = (bit_cnt != '0) ? SHIFT : PARITY;
         end
         PARITY: frame_end = 1'b1;
`else
         SHIFT: begin
            sr_shift = bit_cnt != '0;
            frame_end = bit_cnt == '0;
         end
`endif
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      // rem==0 means continuous; only a count of exactly one ends the run
      if (frame_end) state_nx = (rem == CNT_W'(1)) ? DONE : SHIFT;
      reload = frame_end && (rem != CNT_W'(1)) && !abort;
      if (abort) begin
         state_nx = IDLE;
         accept = 1'b0;
         sr_shift = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         pat <= '0;
         rem <= '0;
         bit_cnt <= '0;
      end else if (accept) begin
         pat <= load_pattern;
         rem <= load_repeat;
         bit_cnt <= LAST;
      end else if (reload) begin
         bit_cnt <= LAST;
         rem <= (rem != '0) ? rem - CNT_W'(1) : rem;
      end else if (sr_shift) bit_cnt <= bit_cnt - BW'(1);

   seq_shift_reg #(.PAT_W(PAT_W)) u_sr (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (accept || reload),
      .shift   (sr_shift),
      .din     (accept ? load_pattern : pat),
      .msb     (sr_msb)
   );

   assign load_ready = (state == IDLE) && !abort;
   assign busy = state != IDLE;
   assign done = state == DONE;
`ifdef SEQ_PATTERN_TX_PARITY_EN
   assign data_out_valid = (state == SHIFT) || (state == PARITY);
   assign data_out = (state == SHIFT) ? sr_msb : (state == PARITY) && (^pat);
`else
   assign data_out_valid = state == SHIFT;
   assign data_out = data_out_valid && sr_msb;
`endif
endmodule
